// File: rtl/exu_disp_ctrl.sv
// rtl/exu_disp_ctrl.sv - dispatch scheduler with in-order OITF hazard tracking (optional EXU_DISP_RET_BYPASS_EN)
module exu_disp_ctrl #(
    parameter int OITF_DEPTH  = 2,
    parameter int RFIDX_WIDTH = 5,
    parameter int ITAG_WIDTH  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic                   dec_rs1en,
    input  logic                   dec_rs2en,
    input  logic                   dec_rdwen,
    input  logic [RFIDX_WIDTH-1:0] dec_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] dec_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] dec_rdidx,
    input  logic                   dec_longp,
    output logic                   disp_valid,
    input  logic                   disp_ready,
    output logic [ITAG_WIDTH-1:0]  disp_itag,
    input  logic                   longp_wbck_valid,
    input  logic [ITAG_WIDTH-1:0]  longp_wbck_itag,
    input  logic                   flush_req,
    output logic                   oitf_empty,
    output logic                   oitf_full,
    output logic                   dep_stall,
    output logic                   itag_err
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam logic [ITAG_WIDTH:0] PTR_ONE = {{ITAG_WIDTH{1'b0}}, 1'b1};

    logic [OITF_DEPTH-1:0]  vld_q;
    logic [OITF_DEPTH-1:0]  rdwen_q;
    logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
    logic [ITAG_WIDTH:0]    alc_ptr_q;
    logic [ITAG_WIDTH:0]    ret_ptr_q;
    logic                   itag_err_q;

    logic                   empty_q;
    logic                   full_q;
    logic                   ret_hit;
    logic                   ret_fire;
    logic                   alc_fire;
    logic                   eff_full;
    logic                   raw1;
    logic                   raw2;
    logic                   waw;
    logic                   dep;
    logic                   block;
    logic [ITAG_WIDTH-1:0]  alc_idx;
    logic [ITAG_WIDTH-1:0]  ret_idx;

    assign alc_idx = alc_ptr_q[ITAG_WIDTH-1:0];
    assign ret_idx = ret_ptr_q[ITAG_WIDTH-1:0];
    assign empty_q = (alc_ptr_q == ret_ptr_q);
    assign full_q  = (alc_idx == ret_idx) && (alc_ptr_q[ITAG_WIDTH] != ret_ptr_q[ITAG_WIDTH]);

    // A retire only counts against a non-empty OITF; a flush in the same cycle discards it.
    assign ret_hit  = longp_wbck_valid & ~empty_q;
    assign ret_fire = ret_hit & ~flush_req;

`ifdef EXU_DISP_RET_BYPASS_EN
    // The retiring head entry frees its slot in the same cycle.
    assign eff_full = full_q & ~ret_hit;
`else
    assign eff_full = full_q;
`endif

    // Hazard match of the decoded operands against every pending long-op destination.
    always_comb begin
        raw1 = 1'b0;
        raw2 = 1'b0;
        waw  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            logic live;
            live = vld_q[i] & rdwen_q[i];
`ifdef EXU_DISP_RET_BYPASS_EN
            if (ret_hit && (ITAG_WIDTH'(i) == ret_idx)) begin
                live = 1'b0;
            end
`endif
            if (live && dec_rs1en && (rdidx_q[i] == dec_rs1idx)) begin
                raw1 = 1'b1;
            end
            if (live && dec_rs2en && (rdidx_q[i] == dec_rs2idx)) begin
                raw2 = 1'b1;
            end
            if (live && dec_rdwen && (rdidx_q[i] == dec_rdidx)) begin
                waw = 1'b1;
            end
        end
    end

    assign dep   = raw1 | raw2 | waw;
    assign block = dep | flush_req | (dec_longp & eff_full);

    // Zero-cycle pass-through handshake; everything is held quiet while in reset.
    assign disp_valid = ~rst & i_valid & ~block;
    assign i_ready    = ~rst & disp_ready & ~block;
    assign dep_stall  = ~rst & i_valid & dep;
    assign disp_itag  = rst ? '0 : alc_idx;
    assign oitf_empty = rst | empty_q;
    assign oitf_full  = ~rst & full_q;
    assign itag_err   = itag_err_q;

    assign alc_fire = disp_valid & disp_ready & dec_longp;

    // OITF valid bits, pointers and sticky tag error; flush rewinds alloc onto retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            alc_ptr_q  <= '0;
            ret_ptr_q  <= '0;
            itag_err_q <= 1'b0;
        end else if (flush_req) begin
            vld_q     <= '0;
            alc_ptr_q <= ret_ptr_q;
        end else begin
            if (ret_fire) begin
                vld_q[ret_idx] <= 1'b0;
                ret_ptr_q      <= ret_ptr_q + PTR_ONE;
            end
            // Alloc after retire so a bypassed alloc into the retiring slot keeps it valid.
            if (alc_fire) begin
                vld_q[alc_idx] <= 1'b1;
                alc_ptr_q      <= alc_ptr_q + PTR_ONE;
            end
            if (longp_wbck_valid && (empty_q || (longp_wbck_itag != ret_idx))) begin
                itag_err_q <= 1'b1;
            end
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (alc_fire) begin
            rdwen_q[alc_idx] <= dec_rdwen;
            rdidx_q[alc_idx] <= dec_rdidx;
        end
    end

endmodule

// File: tb/tb_exu_disp_ctrl.sv
// tb/tb_exu_disp_ctrl.sv - scoreboard bench for exu_disp_ctrl with queue-based OITF reference
module tb_exu_disp_ctrl;

    localparam int DEPTH = 2;
    localparam int RW    = 5;
    localparam int TW    = 1;

    typedef struct {
        logic          rst, iv, rs1en, rs2en, rdwen;
        logic [RW-1:0] rs1, rs2, rd;
        logic          longp, dready, wv;
        logic [TW-1:0] wtag;
        logic          flush;
    } stim_t;

    typedef struct {
        logic          ready, valid, stall, empty, full, err, err_chk;
        logic [TW-1:0] itag;
    } exp_t;

    typedef struct {
        logic          rdwen;
        logic [RW-1:0] rd;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, i_valid, i_ready, dec_rs1en, dec_rs2en, dec_rdwen, dec_longp;
    logic [RW-1:0] dec_rs1idx, dec_rs2idx, dec_rdidx;
    logic          disp_valid, disp_ready, longp_wbck_valid, flush_req;
    logic [TW-1:0] disp_itag, longp_wbck_itag;
    logic          oitf_empty, oitf_full, dep_stall, itag_err;

    exp_t sb[$];
    ent_t oq[$];
    int   alc_n = 0;
    int   ret_n = 0;
    bit   m_err = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    exu_disp_ctrl #(.OITF_DEPTH(DEPTH), .RFIDX_WIDTH(RW), .ITAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .dec_rs1en(dec_rs1en), .dec_rs2en(dec_rs2en), .dec_rdwen(dec_rdwen),
        .dec_rs1idx(dec_rs1idx), .dec_rs2idx(dec_rs2idx), .dec_rdidx(dec_rdidx),
        .dec_longp(dec_longp), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_itag(disp_itag), .longp_wbck_valid(longp_wbck_valid),
        .longp_wbck_itag(longp_wbck_itag), .flush_req(flush_req),
        .oitf_empty(oitf_empty), .oitf_full(oitf_full), .dep_stall(dep_stall),
        .itag_err(itag_err)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [TW-1:0] head_tag();
        return TW'(ret_n % DEPTH);
    endfunction

    // Reference: OITF as an in-order queue of pending destinations plus alloc/retire counts.
    task automatic model(input stim_t s);
        exp_t e;
        bit   byp, dep, full, fire;
        byp = 1'b0;
`ifdef EXU_DISP_RET_BYPASS_EN
        byp = s.wv && (oq.size() > 0);
`endif
        dep = 1'b0;
        foreach (oq[i]) begin
            if (!(byp && i == 0) && oq[i].rdwen) begin
                if (s.rs1en && oq[i].rd == s.rs1) dep = 1'b1;
                if (s.rs2en && oq[i].rd == s.rs2) dep = 1'b1;
                if (s.rdwen && oq[i].rd == s.rd)  dep = 1'b1;
            end
        end
        full      = (oq.size() == DEPTH);
        e.valid   = !s.rst && s.iv && !(dep || s.flush || (s.longp && full && !byp));
        e.ready   = !s.rst && s.dready && !(dep || s.flush || (s.longp && full && !byp));
        e.stall   = !s.rst && s.iv && dep;
        e.itag    = s.rst ? '0 : TW'(alc_n % DEPTH);
        e.empty   = s.rst ? 1'b1 : (oq.size() == 0);
        e.full    = s.rst ? 1'b0 : full;
        e.err     = m_err;
        e.err_chk = !s.rst;
        sb.push_back(e);
        fire = e.valid && s.dready;
        if (s.rst) begin
            oq.delete();
            alc_n = 0;
            ret_n = 0;
            m_err = 1'b0;
        end else if (s.flush) begin
            oq.delete();
            alc_n = ret_n;
        end else begin
            if (s.wv) begin
                if (oq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    if (s.wtag != head_tag()) m_err = 1'b1;
                    void'(oq.pop_front());
                    ret_n++;
                end
            end
            if (fire && s.longp) begin
                oq.push_back('{rdwen: s.rdwen, rd: s.rd});
                alc_n++;
            end
        end
    endtask

    task automatic cyc(input stim_t s);
        @(posedge clk);
        #1;
        rst = s.rst; i_valid = s.iv; dec_rs1en = s.rs1en; dec_rs2en = s.rs2en;
        dec_rdwen = s.rdwen; dec_rs1idx = s.rs1; dec_rs2idx = s.rs2; dec_rdidx = s.rd;
        dec_longp = s.longp; disp_ready = s.dready; longp_wbck_valid = s.wv;
        longp_wbck_itag = s.wtag; flush_req = s.flush;
        model(s);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation, compare the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("i_ready",    8'(i_ready),    8'(e.ready));
                chk("disp_valid", 8'(disp_valid), 8'(e.valid));
                chk("dep_stall",  8'(dep_stall),  8'(e.stall));
                chk("disp_itag",  8'(disp_itag),  8'(e.itag));
                chk("oitf_empty", 8'(oitf_empty), 8'(e.empty));
                chk("oitf_full",  8'(oitf_full),  8'(e.full));
                if (e.err_chk) chk("itag_err", 8'(itag_err), 8'(e.err));
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; i_valid = 0; dec_rs1en = 0; dec_rs2en = 0; dec_rdwen = 0;
        dec_rs1idx = 0; dec_rs2idx = 0; dec_rdidx = 0; dec_longp = 0; disp_ready = 0;
        longp_wbck_valid = 0; longp_wbck_itag = 0; flush_req = 0;

        s = idle(); s.rst = 1; cyc(s); cyc(s);
        // Non-long ADDI rd=x5
        s = idle(); s.iv = 1; s.rdwen = 1; s.rd = 5; s.dready = 1; cyc(s);
        // Long op rd=x3, then dependent ADDI stalls until retire
        s = idle(); s.iv = 1; s.rdwen = 1; s.rd = 3; s.longp = 1; s.dready = 1; cyc(s);
        s = idle(); s.iv = 1; s.rs1en = 1; s.rs1 = 3; s.rdwen = 1; s.rd = 6; s.dready = 1;
        cyc(s); cyc(s);
        s.wv = 1; s.wtag = 0; cyc(s);
        s.wv = 0; cyc(s);
        // Fill to full, blocked third long op, non-long still dispatches
        s = idle(); s.iv = 1; s.rdwen = 1; s.longp = 1; s.dready = 1;
        s.rd = 1; cyc(s); s.rd = 2; cyc(s); s.rd = 4; cyc(s);
        s.longp = 0; s.rd = 7; cyc(s);
        // Retire head while presenting a long op into the full OITF
        s.longp = 1; s.rd = 8; s.wv = 1; s.wtag = head_tag(); cyc(s);
        s.wv = 0; cyc(s);
        // Flush with a concurrent retire, then a reader of x1
        s = idle(); s.flush = 1; s.wv = 1; s.wtag = head_tag(); s.iv = 1; s.dready = 1; cyc(s);
        s = idle(); s.iv = 1; s.rs1en = 1; s.rs1 = 1; s.dready = 1; cyc(s);
        // Retire while empty sets the sticky error; reset clears it
        s = idle(); s.wv = 1; cyc(s);
        s = idle(); cyc(s); cyc(s);
        s.rst = 1; cyc(s);
        s.rst = 0; cyc(s);

        for (int n = 0; n < 3000; n++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.flush = ($urandom_range(0, 29) == 0);
            s.iv    = ($urandom_range(0, 3) != 0);
            s.rs1en = $urandom_range(0, 1);
            s.rs2en = $urandom_range(0, 1);
            s.rdwen = ($urandom_range(0, 3) != 0);
            s.rs1   = RW'($urandom_range(0, 3));
            s.rs2   = RW'($urandom_range(0, 3));
            s.rd    = RW'($urandom_range(0, 3));
            s.longp = ($urandom_range(0, 9) < 4);
            s.dready = ($urandom_range(0, 4) != 0);
            s.wv    = ($urandom_range(0, 2) == 0);
            s.wtag  = ($urandom_range(0, 19) == 0) ? ~head_tag() : head_tag();
            cyc(s);
        end
        s = idle(); cyc(s);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
